// File: rtl/core_s2_amo_sequencer.sv
// Stage-2 RV32A AMO sequencer. Runs a single AMO as load, compute, store and writeback,
// borrowing the shared ALU, its source muxes and the dcache for the duration.
package core_s2_amo_sequencer_pkg;
   typedef enum logic [1:0] {OP1_RS1 = 2'd0, OP1_PC = 2'd1, OP1_DCACHE = 2'd2} alu_op1_src_e;
   typedef enum logic [2:0] {OP2_RS2 = 3'd0, OP2_IMM = 3'd1, OP2_SAVED_RS2 = 3'd2,
                             OP2_CSR = 3'd3} alu_op2_src_e;
endpackage

module core_s2_amo_sequencer
   import core_s2_amo_sequencer_pkg::*;
#(
   parameter int unsigned MAX_WAIT   = 255,
   parameter int unsigned WAIT_CNT_W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         amo_start,
   input  logic         flush,
   input  alu_op1_src_e dec_alu_op1_src,
   input  alu_op2_src_e dec_alu_op2_src,
   input  logic [31:0]  rs2,
   input  logic [31:0]  alu_result,
   input  logic         dcache_load_done,
   input  logic         dcache_store_done,
   output alu_op1_src_e alu_op1_src,
   output alu_op2_src_e alu_op2_src,
   output logic         alu_use_amo_op,
   output logic [31:0]  saved_rs2,
   input  logic [31:0]  dcache_data_out,
   output logic         dcache_load_req,
   output logic         dcache_store_req,
   output logic [31:0]  store_data,
   output logic         rd_we,
   output logic [31:0]  rd_wdata,
   output logic         stall,
   output logic         amo_error,
   output logic [2:0]   o_dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_COMPUTE = 3'd2,
      ST_STORE   = 3'd3,
      ST_WB      = 3'd4
   } state_e;

   localparam logic [WAIT_CNT_W-1:0] LP_LAST_WAIT =
      (MAX_WAIT == 0) ? '0 : WAIT_CNT_W'(MAX_WAIT - 1);

   state_e                r_state;
   state_e                w_state_nxt;
   logic [WAIT_CNT_W-1:0] r_wait_cnt;
   logic [31:0]           r_saved_rs2;
   logic [31:0]           r_rd_wdata;
   logic [31:0]           r_store_data;
   logic                  r_amo_error;
   logic                  w_start;
   logic                  w_wait_expired;
   logic                  w_timeout;
   logic                  w_load_capture;
   logic                  w_store_capture;

   assign w_start        = (r_state == ST_IDLE) && amo_start && !flush;
   assign w_wait_expired = (MAX_WAIT != 0) && (r_wait_cnt == LP_LAST_WAIT);

   // Precedence in LOAD: flush, then load_done, then timeout. STORE ignores flush.
   always_comb begin
      w_state_nxt      = r_state;
      alu_op1_src      = dec_alu_op1_src;
      alu_op2_src      = dec_alu_op2_src;
      alu_use_amo_op   = 1'b0;
      dcache_load_req  = 1'b0;
      dcache_store_req = 1'b0;
      rd_we            = 1'b0;
      stall            = 1'b0;
      w_timeout        = 1'b0;
      w_load_capture   = 1'b0;
      w_store_capture  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            stall = w_start;
            if (w_start) w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            alu_op1_src     = OP1_RS1;
            alu_op2_src     = OP2_IMM;
            dcache_load_req = 1'b1;
            stall           = 1'b1;
            if (flush) begin
               w_state_nxt = ST_IDLE;
            end else if (dcache_load_done) begin
               w_load_capture = 1'b1;
               w_state_nxt    = ST_COMPUTE;
            end else if (w_wait_expired) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_COMPUTE: begin
            alu_op1_src     = OP1_DCACHE;
            alu_op2_src     = OP2_SAVED_RS2;
            alu_use_amo_op  = 1'b1;
            stall           = 1'b1;
            w_store_capture = 1'b1;
            w_state_nxt     = ST_STORE;
         end
         ST_STORE: begin
            alu_op1_src      = OP1_RS1;
            alu_op2_src      = OP2_IMM;
            dcache_store_req = 1'b1;
            stall            = 1'b1;
            if (dcache_store_done) begin
               w_state_nxt = ST_WB;
            end else if (w_wait_expired) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WB: begin
            rd_we       = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_wait_cnt   <= '0;
         r_saved_rs2  <= '0;
         r_rd_wdata   <= '0;
         r_store_data <= '0;
         r_amo_error  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_amo_error <= w_timeout;
         // The wait counter measures time spent in the current state only.
         if (w_state_nxt != r_state)
            r_wait_cnt <= '0;
         else if (r_state == ST_LOAD || r_state == ST_STORE)
            r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
         if (w_start)         r_saved_rs2  <= rs2;
         if (w_load_capture)  r_rd_wdata   <= dcache_data_out;
         if (w_store_capture) r_store_data <= alu_result;
      end
   end

   assign saved_rs2   = r_saved_rs2;
   assign rd_wdata    = r_rd_wdata;
   assign store_data  = r_store_data;
   assign amo_error   = r_amo_error;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_core_s2_amo_sequencer.sv
// Bench for core_s2_amo_sequencer: drives AMOs against a small ALU/dcache model and
// scoreboards each writeback (old value and stored result) as the DUT produces it.
module tb_core_s2_amo_sequencer;
   import core_s2_amo_sequencer_pkg::*;

   localparam logic [31:0] RS1_VAL = 32'h0000_1000;

   logic         clk;
   logic         rst;
   logic         amo_start;
   logic         flush;
   alu_op1_src_e dec_alu_op1_src;
   alu_op2_src_e dec_alu_op2_src;
   logic [31:0]  rs2;
   logic [31:0]  alu_result;
   logic         dcache_load_done;
   logic         dcache_store_done;
   alu_op1_src_e alu_op1_src;
   alu_op2_src_e alu_op2_src;
   logic         alu_use_amo_op;
   logic [31:0]  saved_rs2;
   logic [31:0]  dcache_data_out;
   logic         dcache_load_req;
   logic         dcache_store_req;
   logic [31:0]  store_data;
   logic         rd_we;
   logic [31:0]  rd_wdata;
   logic         stall;
   logic         amo_error;
   logic [2:0]   o_dbg_state;

   logic [3:0]   cur_op;
   logic [31:0]  op_a;
   logic [31:0]  op_b;
   logic [31:0]  last_old;
   logic [63:0]  exp_q[$];
   int           n_checks;
   int           n_errors;

   core_s2_amo_sequencer #(.MAX_WAIT(4), .WAIT_CNT_W(8)) dut (
      .clk(clk), .rst(rst), .amo_start(amo_start), .flush(flush),
      .dec_alu_op1_src(dec_alu_op1_src), .dec_alu_op2_src(dec_alu_op2_src),
      .rs2(rs2), .alu_result(alu_result),
      .dcache_load_done(dcache_load_done), .dcache_store_done(dcache_store_done),
      .alu_op1_src(alu_op1_src), .alu_op2_src(alu_op2_src),
      .alu_use_amo_op(alu_use_amo_op), .saved_rs2(saved_rs2),
      .dcache_data_out(dcache_data_out), .dcache_load_req(dcache_load_req),
      .dcache_store_req(dcache_store_req), .store_data(store_data),
      .rd_we(rd_we), .rd_wdata(rd_wdata), .stall(stall), .amo_error(amo_error),
      .o_dbg_state(o_dbg_state)
   );

   // Clock/reset: 10 ns period, inputs driven 1 ns after posedge, sampled 3 ns after.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 0 SWAP, 1 ADD, 2 AND, 3 OR, 4 XOR, 5 MIN, 6 MAX, 7 MINU, 8 MAXU
   function automatic logic [31:0] amo_model(input logic [3:0] op, input logic [31:0] m,
                                              input logic [31:0] s);
      case (op)
         4'd0:    return s;
         4'd1:    return m + s;
         4'd2:    return m & s;
         4'd3:    return m | s;
         4'd4:    return m ^ s;
         4'd5:    return ($signed(m) < $signed(s)) ? m : s;
         4'd6:    return ($signed(m) > $signed(s)) ? m : s;
         4'd7:    return (m < s) ? m : s;
         default: return (m > s) ? m : s;
      endcase
   endfunction

   // Environment ALU and source muxes fed by the DUT's selects.
   always_comb begin
      op_a = (alu_op1_src == OP1_DCACHE) ? rd_wdata : RS1_VAL;
      op_b = (alu_op2_src == OP2_SAVED_RS2) ? saved_rs2 :
             (alu_op2_src == OP2_IMM) ? 32'h0 : rs2;
      alu_result = alu_use_amo_op ? amo_model(cur_op, op_a, op_b) : op_a + op_b;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: every rd_we must match the oldest outstanding AMO.
   always @(negedge clk) begin
      if (!rst && rd_we) begin
         if (exp_q.size() == 0) begin
            check("wb_unexpected", 1, 0);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("wb_rd_wdata", rd_wdata, e[31:0]);
            check("wb_store_data", store_data, e[63:32]);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // mode: 0 normal, 1 flush in LOAD cycle 2, 2 flush with load_done, 3 flush through
   // COMPUTE/STORE, 4 load timeout, 5 async reset in COMPUTE, 6 amo_start held in WB.
   task automatic run_amo(input logic [3:0] op, input logic [31:0] rs2v, input logic [31:0] memv,
                          input int ld_lat, input int st_lat, input int mode);
      int          stalls;
      logic [31:0] exp_st;
      stalls = 0;
      cur_op = op;
      exp_st = amo_model(op, memv, rs2v);
      amo_start = 1'b1;
      rs2 = rs2v;
      dec_alu_op1_src = OP1_PC;
      dec_alu_op2_src = OP2_CSR;
      if (mode == 0 || mode == 3 || mode == 6) exp_q.push_back({exp_st, memv});
      #2;
      check("start_state", o_dbg_state, 3'd0);
      check("start_stall", stall, 1);
      if (stall) stalls++;
      next_cycle();
      amo_start = 1'b0;
      rs2 = $urandom;
      for (int i = 1; i <= ld_lat; i++) begin
         dcache_data_out = $urandom;
         if (i == ld_lat && mode != 1 && mode != 4) begin
            dcache_load_done = 1'b1;
            dcache_data_out  = memv;
         end
         if ((mode == 1 && i == 2) || (mode == 2 && i == ld_lat)) flush = 1'b1;
         #2;
         check("ld_req", dcache_load_req, 1);
         check("ld_op1", alu_op1_src, OP1_RS1);
         check("ld_op2", alu_op2_src, OP2_IMM);
         check("ld_amo_op", alu_use_amo_op, 0);
         check("ld_saved_rs2", saved_rs2, rs2v);
         check("ld_error", amo_error, 0);
         if (stall) stalls++;
         next_cycle();
         dcache_load_done = 1'b0;
         flush = 1'b0;
         if ((mode == 1 && i == 2) || (mode == 2 && i == ld_lat)) begin
            #2;
            check("flush_state", o_dbg_state, 3'd0);
            check("flush_ld_req", dcache_load_req, 0);
            check("flush_stall", stall, 0);
            check("flush_rd_wdata", rd_wdata, last_old);
            next_cycle();
            check("flush_no_store", dcache_store_req, 0);
            return;
         end
      end
      if (mode == 4) begin
         #2;
         check("to_error", amo_error, 1);
         check("to_state", o_dbg_state, 3'd0);
         check("to_stall", stall, 0);
         check("to_ld_req", dcache_load_req, 0);
         next_cycle();
         check("to_error_pulse", amo_error, 0);
         return;
      end
      // COMPUTE
      if (mode == 3) flush = 1'b1;
      if (mode == 5) begin
         dec_alu_op1_src = OP1_RS1;
         dec_alu_op2_src = OP2_RS2;
         #1;
         check("rst_pre_state", o_dbg_state, 3'd2);
         rst = 1'b1;
         #1;
         check("rst_state", o_dbg_state, 3'd0);
         check("rst_stall", stall, 0);
         check("rst_amo_op", alu_use_amo_op, 0);
         check("rst_op1", alu_op1_src, OP1_RS1);
         check("rst_op2", alu_op2_src, OP2_RS2);
         check("rst_rd_wdata", rd_wdata, 0);
         check("rst_saved_rs2", saved_rs2, 0);
         check("rst_reqs", {dcache_load_req, dcache_store_req, rd_we, amo_error}, 0);
         #3;
         rst = 1'b0;
         last_old = 32'h0;
         next_cycle();
         check("rst_idle", o_dbg_state, 3'd0);
         check("rst_no_store", dcache_store_req, 0);
         return;
      end
      #2;
      check("cp_op1", alu_op1_src, OP1_DCACHE);
      check("cp_op2", alu_op2_src, OP2_SAVED_RS2);
      check("cp_amo_op", alu_use_amo_op, 1);
      check("cp_rd_wdata", rd_wdata, memv);
      if (stall) stalls++;
      next_cycle();
      for (int j = 1; j <= st_lat; j++) begin
         if (j == st_lat) dcache_store_done = 1'b1;
         #2;
         check("st_req", dcache_store_req, 1);
         check("st_op1", alu_op1_src, OP1_RS1);
         check("st_op2", alu_op2_src, OP2_IMM);
         check("st_data", store_data, exp_st);
         if (stall) stalls++;
         next_cycle();
         dcache_store_done = 1'b0;
      end
      // WB
      flush = 1'b0;
      if (mode == 6) begin
         amo_start = 1'b1;
         rs2 = ~rs2v;
      end
      #2;
      check("wb_state", o_dbg_state, 3'd4);
      check("wb_rd_we", rd_we, 1);
      check("wb_stall", stall, 0);
      check("stall_cycles", stalls, ld_lat + st_lat + 2);
      last_old = memv;
      next_cycle();
      if (mode == 6) begin
         check("wb_start_ignored", saved_rs2, rs2v);
      end else begin
         amo_start = 1'b0;
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      amo_start = 1'b0;
      flush = 1'b0;
      dec_alu_op1_src = OP1_RS1;
      dec_alu_op2_src = OP2_RS2;
      rs2 = 32'h0;
      dcache_load_done = 1'b0;
      dcache_store_done = 1'b0;
      dcache_data_out = 32'h0;
      cur_op = 4'd1;
      last_old = 32'h0;
      repeat (2) next_cycle();
      check("reset_state", o_dbg_state, 3'd0);
      check("reset_outs", {stall, dcache_load_req, dcache_store_req, rd_we, amo_error,
                           alu_use_amo_op}, 0);
      check("reset_regs", {saved_rs2, rd_wdata}, 0);
      rst = 1'b0;
      next_cycle();

      // Passthrough in IDLE
      dec_alu_op1_src = OP1_PC;
      dec_alu_op2_src = OP2_CSR;
      #2;
      check("pass_op1", alu_op1_src, OP1_PC);
      check("pass_op2", alu_op2_src, OP2_CSR);
      check("pass_stall", stall, 0);
      next_cycle();

      run_amo(4'd1, 32'd5, 32'h10, 3, 2, 0);
      for (int k = 0; k < 10; k++)
         run_amo(4'($urandom_range(0, 8)), $urandom, $urandom,
                 $urandom_range(1, 4), $urandom_range(1, 4), 0);
      run_amo(4'd5, 32'h8000_0000, 32'h7fff_ffff, 2, 2, 0);
      run_amo(4'd7, 32'h8000_0000, 32'h7fff_ffff, 2, 2, 0);
      run_amo(4'd1, 32'h1, 32'hdead_0001, 3, 1, 1);
      run_amo(4'd2, 32'h2, 32'hdead_0002, 2, 1, 2);
      run_amo(4'd3, 32'h0f0f_0000, 32'h0000_f0f0, 1, 3, 3);
      run_amo(4'd4, 32'h3, 32'hdead_0004, 4, 1, 4);
      run_amo(4'd0, 32'haaaa_5555, 32'h1234_5678, 1, 1, 6);
      run_amo(4'd8, 32'h0000_0007, 32'hffff_fff0, 2, 2, 0);
      run_amo(4'd6, 32'h11, 32'h22, 2, 1, 5);
      run_amo(4'd1, 32'h100, 32'h200, 1, 1, 0);

      repeat (3) next_cycle();
      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/core_s2_amo_sequencer.md
Name: core_s2_amo_sequencer

Overview:
- Stage-2 controller that sequences one RV32A AMO (AMOSWAP/ADD/AND/OR/XOR/MIN/MAX/MINU/MAXU.W) through the shared ALU, its source muxes and the dcache.
- Idle: forwards the decoder's ALU source selects unchanged.
- Active: overrides the selects, owns saved_rs2, drives dcache load/store requests, stalls the pipe and issues a final rd writeback of the old memory value.

Parameters:
- MAX_WAIT, 255: max cycles spent in LOAD or STORE before abort with error; 0 disables the timeout.
- WAIT_CNT_W, 8: width of the wait counter; must satisfy 2^WAIT_CNT_W > MAX_WAIT.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- amo_start  in  1  valid AMO in s2 this cycle (single-cycle qualifier)
- flush  in  1  s2 flush/kill
- dec_alu_op1_src  in  alu_op1_src_e(2)  decoder's op1 select
- dec_alu_op2_src  in  alu_op2_src_e(3)  decoder's op2 select
- rs2  in  32  rs2 value at start
- alu_result  in  32  ALU output
- dcache_load_done  in  1  load data valid on dcache_data_out (pulse)
- dcache_store_done  in  1  store accepted (pulse)
- alu_op1_src  out  alu_op1_src_e(2)  select to ALU src mux
- alu_op2_src  out  alu_op2_src_e(3)  select to ALU src mux
- alu_use_amo_op  out  1  1: ALU performs AMO function; 0: ALU performs ADD
- saved_rs2  out  32  latched rs2 for the mux
- dcache_data_out  in  32  load data
- dcache_load_req  out  1  load request (address = ALU result)
- dcache_store_req  out  1  store request (address = ALU result)
- store_data  out  32  AMO result to store
- rd_we  out  1  writeback enable
- rd_wdata  out  32  old memory value
- stall  out  1  hold s1/s2
- amo_error  out  1  timeout abort (pulse)

Behaviour:
- Encodings:
  - op1: RS1=0, PC=1, DCACHE=2.
  - op2: RS2=0, IMM=1, SAVED_RS2=2, CSR=3.
  - IMM is zero for AMOs.
- States: IDLE, LOAD, COMPUTE, STORE, WB. Reset → IDLE.
- Reset values: all registers 0; outputs stall=0, req=0, rd_we=0, amo_error=0, alu_use_amo_op=0.
- IDLE:
  - alu_op1_src/alu_op2_src = dec_* (combinational passthrough).
  - On amo_start & !flush: saved_rs2<=rs2, wait_cnt<=0, go LOAD.
  - stall = amo_start & !flush (same cycle).
- LOAD:
  - Drives op1=RS1, op2=IMM, alu_use_amo_op=0, dcache_load_req=1, stall=1.
  - On dcache_load_done: rd_wdata<=dcache_data_out, go COMPUTE.
  - flush (without load_done) → IDLE, no side effects.
  - If load_done and flush are simultaneous, flush wins → IDLE.
- COMPUTE:
  - Exactly 1 cycle: op1=DCACHE, op2=SAVED_RS2, alu_use_amo_op=1, stall=1.
  - store_data<=alu_result, go STORE.
  - Flush is ignored from COMPUTE onward.
- STORE:
  - Drives op1=RS1, op2=IMM, alu_use_amo_op=0, dcache_store_req=1, stall=1.
  - On dcache_store_done → WB.
- WB:
  - 1 cycle: rd_we=1, stall=0 (the pipe advances this cycle), then IDLE.
  - amo_start in WB is not accepted; the next AMO may start on the following cycle.
- Timeout:
  - wait_cnt increments each cycle in LOAD/STORE and clears on every state change.
  - If MAX_WAIT≠0 and wait_cnt==MAX_WAIT-1 with no done: amo_error=1 for 1 cycle, go IDLE, rd_we is never asserted.
  - A done arriving on that same cycle takes priority over the timeout.
- dcache_load_req/dcache_store_req are held high continuously until done, abort or timeout.
- saved_rs2 changes only on accepted start.
- rd_wdata/store_data hold their values until overwritten.
- Async reset mid-operation: immediate return to IDLE with all outputs at reset values; no writeback.

Test Plan:
- AMOADD: rs2=5, mem returns 0x10 after 3 cycles, store_done after 2 cycles → op selects follow LOAD/COMPUTE/STORE encodings; store_data=0x15; rd_we pulse with rd_wdata=0x10; stall high 7 cycles then low in WB.
- Passthrough: IDLE, dec_op1=PC, dec_op2=CSR, no start → outputs 1/3 same cycle; stall=0.
- Flush in LOAD on cycle 2 → IDLE next cycle; no store_req or rd_we. Simultaneous load_done+flush → IDLE; rd_we never asserted.
- Flush asserted in STORE → ignored; store completes; rd_we pulses.
- MAX_WAIT=4, load_done never arrives → amo_error pulse 4 cycles after entering LOAD; return to IDLE; stall=0.
- Reset asserted in COMPUTE (async, mid-cycle) → all outputs 0 immediately; IDLE after deassert. Back-to-back amo_start in WB → ignored; accepted on the next cycle.
